// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding and load-use hazard detection
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              id_valid,
    input  logic [2:0]        id_alu_ctrl,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [REG_AW-1:0] wb_fwd_addr,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_mem_read
);
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [2:0]        ctrl_q;
    logic              valid_q, use_imm_q, reg_write_q, mem_read_q;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    // Load in EX whose destination is read by the instruction in ID; a flush makes the stall moot
    always_comb begin
        hazard_stall = !flush_in && id_valid && valid_q && mem_read_q && rd_q != '0 &&
                       (rd_q == id_rs_addr || (!id_use_imm && rd_q == id_rt_addr));
    end

    // Pipeline register: reset/flush/hazard load a bubble, downstream stall holds, otherwise capture ID
    always_ff @(posedge clk) begin
        if (rst || flush_in || (!stall_in && hazard_stall)) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (!stall_in) begin
            valid_q     <= id_valid;
            ctrl_q      <= id_alu_ctrl;
            rs_q        <= id_rs_addr;
            rt_q        <= id_rt_addr;
            rd_q        <= id_rd_addr;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm;
            use_imm_q   <= id_use_imm;
            reg_write_q <= id_valid && id_reg_write;
            mem_read_q  <= id_valid && id_mem_read;
        end
    end

    // Operand forwarding: youngest producer (EX/MEM) wins, register 0 is never forwarded
    always_comb begin
        fwd_a = (rs_q != '0 && rs_q == mem_fwd_addr) ? mem_fwd_data :
                (rs_q != '0 && rs_q == wb_fwd_addr)  ? wb_fwd_data  : rs_data_q;
        fwd_b = (rt_q != '0 && rt_q == mem_fwd_addr) ? mem_fwd_data :
                (rt_q != '0 && rt_q == wb_fwd_addr)  ? wb_fwd_data  : rt_data_q;
        alu_a     = valid_q ? fwd_a : '0;
        alu_b     = !valid_q ? '0 : use_imm_q ? imm_q : fwd_b;
        alu_shamt = valid_q ? imm_q[10:6] : '0;
    end

    assign ex_valid     = valid_q;
    assign alu_ctrl     = ctrl_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard-driven bench for the ID/EX pipeline register
module tb_id_ex_stage;
    typedef logic [79:0] obs_t;

    logic        clk = 1'b0;
    logic        rst, stall_in, flush_in, id_valid, id_use_imm, id_reg_write, id_mem_read;
    logic [2:0]  id_alu_ctrl;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, mem_fwd_addr, wb_fwd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm, mem_fwd_data, wb_fwd_data;
    logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt, ex_rd_addr;

    int   checks = 0;
    int   errors = 0;
    obs_t q[$];
    obs_t e;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
        .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_ctrl(alu_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic v, logic [2:0] c, logic [31:0] a, logic [31:0] b,
                                logic [4:0] sh, logic [4:0] rd, logic rw, logic mr);
        return {v, c, a, b, sh, rd, rw, mr};
    endfunction

    function automatic obs_t obs();
        return {ex_valid, alu_ctrl, alu_a, alu_b, alu_shamt, ex_rd_addr, ex_reg_write, ex_mem_read};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(logic v, logic [2:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                          logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                          logic ui, logic rw, logic mr);
        id_valid = v; id_alu_ctrl = c; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_use_imm = ui; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic set_random_id();
        set_id(1'b1, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               $urandom, $urandom, $urandom, 1'($urandom), 1'b1, 1'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        mem_fwd_addr = '0; mem_fwd_data = '0; wb_fwd_addr = '0; wb_fwd_data = '0;
        for (int i = 0; i < 2; i++) begin
            set_random_id();
            q.push_back('0);
            tick();
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got=%h want=%h", i, obs(), e);
            end
            checks++;
            if (hazard_stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_hazard cycle %0d got=%b want=0", i, hazard_stall);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_capture();
        set_id(1'b1, 3'b010, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0);
        q.push_back(mk(1'b1, 3'b010, 32'd5, 32'd7, 5'd0, 5'd9, 1'b1, 1'b0));
        set_id(1'b1, 3'b101, 5'd2, 5'd6, 5'd11, 32'h1234, 32'h9999, 32'h140, 1'b1, 1'b1, 1'b0);
        set_id(1'b1, 3'b010, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL add_capture got=%h want=%h", obs(), e);
        end
        set_id(1'b1, 3'b101, 5'd2, 5'd6, 5'd11, 32'h1234, 32'h9999, 32'h140, 1'b1, 1'b1, 1'b0);
        q.push_back(mk(1'b1, 3'b101, 32'h1234, 32'h140, 5'd5, 5'd11, 1'b1, 1'b0));
        tick();
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL imm_shamt_capture got=%h want=%h", obs(), e);
        end
        set_id(1'b0, 3'b000, 5'd2, 5'd6, 5'd0, 32'h55, 32'h66, 32'h7c0, 1'b0, 1'b1, 1'b1);
        q.push_back(mk(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0));
        tick();
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL invalid_capture got=%h want=%h", obs(), e);
        end
    endtask

    task automatic test_forward();
        set_id(1'b1, 3'b010, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        mem_fwd_addr = 5'd3; mem_fwd_data = 32'hAA;
        wb_fwd_addr  = 5'd3; wb_fwd_data  = 32'hBB;
        #1;
        checks++;
        if (alu_a !== 32'hAA) begin
            errors++;
            $display("FAIL fwd_mem_priority got=%h want=%h", alu_a, 32'hAA);
        end
        mem_fwd_addr = 5'd0;
        #1;
        checks++;
        if (alu_a !== 32'hBB) begin
            errors++;
            $display("FAIL fwd_wb got=%h want=%h", alu_a, 32'hBB);
        end
        wb_fwd_addr = 5'd4; wb_fwd_data = 32'hCC;
        #1;
        checks++;
        if (alu_a !== 32'h11 || alu_b !== 32'hCC) begin
            errors++;
            $display("FAIL fwd_b_wb got a=%h b=%h want a=11 b=cc", alu_a, alu_b);
        end
        set_id(1'b1, 3'b000, 5'd0, 5'd4, 5'd1, 32'h77, 32'h22, 32'h55, 1'b1, 1'b1, 1'b0);
        tick();
        mem_fwd_addr = 5'd0; mem_fwd_data = 32'hDEAD;
        wb_fwd_addr  = 5'd4; wb_fwd_data  = 32'hBEEF;
        #1;
        checks++;
        if (alu_a !== 32'h77 || alu_b !== 32'h55) begin
            errors++;
            $display("FAIL fwd_r0_and_imm got a=%h b=%h want a=77 b=55", alu_a, alu_b);
        end
        mem_fwd_addr = '0; wb_fwd_addr = '0; mem_fwd_data = '0; wb_fwd_data = '0;
    endtask

    task automatic test_hazard();
        set_id(1'b1, 3'b010, 5'd1, 5'd8, 5'd8, 32'h100, 32'h0, 32'h4, 1'b1, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'b010, 5'd2, 5'd8, 5'd10, 32'h20, 32'h30, 32'h0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL hazard_rt got=%b want=1", hazard_stall);
        end
        id_use_imm = 1'b1;
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL hazard_rt_imm got=%b want=0", hazard_stall);
        end
        id_rs_addr = 5'd8;
        #1;
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL hazard_rs got=%b want=1", hazard_stall);
        end
        flush_in = 1'b1;
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL hazard_flush_mask got=%b want=0", hazard_stall);
        end
        flush_in = 1'b0;
        id_rs_addr = 5'd2; id_use_imm = 1'b0;
        stall_in = 1'b1;
        q.push_back(mk(1'b1, 3'b010, 32'h100, 32'h4, 5'd0, 5'd8, 1'b1, 1'b1));
        tick();
        e = q.pop_front();
        checks++;
        if (obs() !== e || hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL hazard_hold_wins got=%h hz=%b want=%h hz=1", obs(), hazard_stall, e);
        end
        stall_in = 1'b0;
        q.push_back('0);
        tick();
        e = q.pop_front();
        checks++;
        if (obs() !== e || hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL hazard_bubble got=%h hz=%b want=%h hz=0", obs(), hazard_stall, e);
        end
        q.push_back(mk(1'b1, 3'b010, 32'h20, 32'h30, 5'd0, 5'd10, 1'b1, 1'b0));
        tick();
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL hazard_retry got=%h want=%h", obs(), e);
        end
    endtask

    task automatic test_stall_flush();
        set_id(1'b1, 3'b110, 5'd5, 5'd6, 5'd7, 32'h50, 32'h60, 32'h0, 1'b0, 1'b1, 1'b0);
        q.push_back(mk(1'b1, 3'b110, 32'h50, 32'h60, 5'd0, 5'd7, 1'b1, 1'b0));
        tick();
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL stall_setup got=%h want=%h", obs(), e);
        end
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_random_id();
            q.push_back(e);
            tick();
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got=%h want=%h", i, obs(), e);
            end
        end
        flush_in = 1'b1;
        q.push_back('0);
        tick();
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL flush_during_stall got=%h want=%h", obs(), e);
        end
        flush_in = 1'b0; stall_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rd;
        logic        ui;
        for (int i = 0; i < 8; i++) begin
            rsd = $urandom; rtd = $urandom; imm = $urandom;
            rd = 5'($urandom_range(1, 31)); ui = 1'(i);
            set_id(1'b1, 3'(i), 5'd12, 5'd13, rd, rsd, rtd, imm, ui, 1'b1, 1'b0);
            q.push_back(mk(1'b1, 3'(i), rsd, ui ? imm : rtd, imm[10:6], rd, 1'b1, 1'b0));
            tick();
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL back_to_back %0d got=%h want=%h", i, obs(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_forward();
        test_hazard();
        test_stall_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
